// File: rtl/dumper_pkg.sv
// dumper_pkg: definitions shared by the RAM image dumper and the memory controller.
//   - Memory map constants, so both blocks agree on where the RAM image lives.
//   - UART frame length (start + 8 data + stop).
//   - Dumper FSM state encoding. The states are kept as plain constants so that
//     legacy code can compare against them directly.
package dumper_pkg;

   // Memory map
   localparam int unsigned RAM_BASE  = 90700;
   localparam int unsigned RAM_WORDS = 129600;
   localparam int unsigned ROM_BASE  = 400;
   localparam int unsigned SENO_BASE = 90400;

   // 8N1 frame: start bit, 8 data bits, stop bit
   localparam int unsigned UART_FRAME_BITS = 10;

   // Dumper FSM states
   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE = 3'd0;
   localparam state_t ST_ADDR = 3'd1;
   localparam state_t ST_WAIT = 3'd2;
   localparam state_t ST_SEND = 3'd3;
   localparam state_t ST_NEXT = 3'd4;
   localparam state_t ST_DONE = 3'd5;
   localparam state_t ST_CSUM = 3'd6;  // only reachable with DUMP_CHECKSUM_EN

endpackage

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter.
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   tx_start  in   load tx_data and begin a frame (ignored while tx_busy)
//   tx_data   in   byte to send, LSB first
//   tx        out  serial line, idle high
//   tx_busy   out  high while a frame is on the line
//   tx_done   out  one-cycle pulse after the stop bit has completed
// Every bit (start, data, stop) lasts exactly CLKS_PER_BIT cycles.
module uart_tx
   import dumper_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       tx,
   output logic       tx_busy,
   output logic       tx_done
);

   localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned BIT_W  = $clog2(UART_FRAME_BITS);

   logic [BAUD_W-1:0] baud_q;
   logic [BIT_W-1:0]  bit_q;
   logic [8:0]        shift_q;  // remaining data bits followed by the stop bit
   logic              tx_q;
   logic              busy_q;
   logic              done_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '1;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (!busy_q) begin
            if (tx_start) begin
               busy_q  <= 1'b1;
               tx_q    <= 1'b0;  // start bit goes out immediately
               shift_q <= {1'b1, tx_data};
               baud_q  <= '0;
               bit_q   <= '0;
            end
         end else if (baud_q == BAUD_W'(CLKS_PER_BIT - 1)) begin
            baud_q <= '0;
            if (bit_q == BIT_W'(UART_FRAME_BITS - 1)) begin
               // stop bit has had its full cell
               busy_q <= 1'b0;
               done_q <= 1'b1;
               tx_q   <= 1'b1;
            end else begin
               tx_q    <= shift_q[0];
               shift_q <= {1'b1, shift_q[8:1]};
               bit_q   <= bit_q + 1'b1;
            end
         end else begin
            baud_q <= baud_q + 1'b1;
         end
      end
   end

   assign tx      = tx_q;
   assign tx_busy = busy_q;
   assign tx_done = done_q;

endmodule

// File: rtl/ram_uart_dumper.sv
// ram_uart_dumper: walks the RAM image through the memory controller and streams
// the low byte of every word over an 8N1 UART line.
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset (aborts a dump at once)
//   start        in   one-cycle pulse, begins a dump when idle
//   mem_rd       in   read data from the memory controller (only [7:0] used)
//   mem_address  out  address to the memory controller
//   mem_sel      out  high while this block owns the controller address port
//   tx           out  UART serial output, idle high
//   busy         out  high from accepted start until the DONE state is left
//   done         out  one-cycle pulse after the final stop bit
// Build option: define DUMP_CHECKSUM_EN to append an XOR checksum frame after the
// last pixel.
module ram_uart_dumper
   import dumper_pkg::*;
#(
   parameter int unsigned BASE_ADDR    = RAM_BASE,
   parameter int unsigned NUM_WORDS    = RAM_WORDS,
   parameter int unsigned READ_LAT     = 2,
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] mem_rd,
   output logic [31:0] mem_address,
   output logic        mem_sel,
   output logic        tx,
   output logic        busy,
   output logic        done
);

   // One spare index bit so the last index never sits at the wrap point.
   localparam int unsigned IDX_W  = $clog2(NUM_WORDS) + 1;
   localparam int unsigned WAIT_W = (READ_LAT > 0) ? $clog2(READ_LAT + 1) : 1;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [31:0]       addr_q, addr_d;

   logic              tx_start;
   logic [7:0]        tx_data;
   logic              tx_done;
   logic              unused_tx_busy;
   logic              unused_rd;

`ifdef DUMP_CHECKSUM_EN
   logic [7:0]        csum_q, csum_d;
   logic              last_q, last_d;  // frame in flight is the checksum
`endif

   assign unused_rd = ^mem_rd[31:8];

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      wait_d   = wait_q;
      addr_d   = addr_q;
      tx_start = 1'b0;
      tx_data  = mem_rd[7:0];
`ifdef DUMP_CHECKSUM_EN
      csum_d   = csum_q;
      last_d   = last_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_ADDR;
               idx_d   = '0;
`ifdef DUMP_CHECKSUM_EN
               csum_d  = '0;
               last_d  = 1'b0;
`endif
            end
         end
         ST_ADDR: begin
            addr_d  = BASE_ADDR + 32'(idx_q);
            wait_d  = WAIT_W'(READ_LAT);
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // Counter reaches 0 only after READ_LAT full cycles on a stable address.
            if (wait_q == '0) begin
               tx_start = 1'b1;
               state_d  = ST_SEND;
`ifdef DUMP_CHECKSUM_EN
               csum_d   = csum_q ^ mem_rd[7:0];
`endif
            end else begin
               wait_d = wait_q - 1'b1;
            end
         end
         ST_SEND: begin
            if (tx_done) begin
`ifdef DUMP_CHECKSUM_EN
               state_d = last_q ? ST_DONE : ST_NEXT;
`else
               state_d = ST_NEXT;
`endif
            end
         end
         ST_NEXT: begin
            if (idx_q == IDX_W'(NUM_WORDS - 1)) begin
`ifdef DUMP_CHECKSUM_EN
               // Reuse the wait counter to keep the usual idle gap before the
               // checksum frame.
               wait_d  = WAIT_W'(READ_LAT);
               state_d = ST_CSUM;
`else
               state_d = ST_DONE;
`endif
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = ST_ADDR;
            end
         end
`ifdef DUMP_CHECKSUM_EN
         ST_CSUM: begin
            if (wait_q == '0) begin
               tx_start = 1'b1;
               tx_data  = csum_q;
               last_d   = 1'b1;
               state_d  = ST_SEND;
            end else begin
               wait_d = wait_q - 1'b1;
            end
         end
`endif
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         wait_q  <= '0;
         addr_q  <= BASE_ADDR;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         wait_q  <= wait_d;
         addr_q  <= addr_d;
      end
   end

`ifdef DUMP_CHECKSUM_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         csum_q <= '0;
         last_q <= 1'b0;
      end else begin
         csum_q <= csum_d;
         last_q <= last_d;
      end
   end
`endif

   uart_tx #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_uart_tx (
      .clk      (clk),
      .rst_n    (rst_n),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .tx       (tx),
      .tx_busy  (unused_tx_busy),
      .tx_done  (tx_done)
   );

   // Outputs decode straight from the state register so reset clears them at once.
   assign mem_address = addr_q;
   assign mem_sel     = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign busy        = (state_q != ST_IDLE);
   assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_ram_uart_dumper.sv
// Bench for ram_uart_dumper with a small image: random pixel patterns are fed from
// a pipelined memory model; a UART line decoder checks every frame against the
// expected byte sequence computed from the address rule.
module tb_ram_uart_dumper;

   localparam int unsigned BASE = 90700;
   localparam int unsigned N    = 4;
   localparam int unsigned LAT  = 2;
   localparam int unsigned CPB  = 4;
   localparam int unsigned FB   = 10 * CPB;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [31:0] mem_rd;
   logic [31:0] mem_address;
   logic        mem_sel;
   logic        tx;
   logic        busy;
   logic        done;

   ram_uart_dumper #(
      .BASE_ADDR    (BASE),
      .NUM_WORDS    (N),
      .READ_LAT     (LAT),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .mem_rd      (mem_rd),
      .mem_address (mem_address),
      .mem_sel     (mem_sel),
      .tx          (tx),
      .busy        (busy),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Memory model: READ_LAT-deep pipeline, low byte = addr[7:0] ^ mask.
   logic [7:0]  mask;
   logic [23:0] upper;
   logic [31:0] rd_p1;
   always @(posedge clk) begin
      rd_p1  <= {upper, mem_address[7:0] ^ mask};
      mem_rd <= rd_p1;
   end

   // Reference: byte k of the dump and the checksum over all N pixels.
   function automatic logic [7:0] pix(input int unsigned k);
      logic [31:0] a;
      a = BASE + k;
      return a[7:0] ^ mask;
   endfunction

   function automatic logic [7:0] csum();
      logic [7:0] c;
      c = 8'h00;
      for (int k = 0; k < N; k++) c = c ^ pix(k);
      return c;
   endfunction

   // UART line decoder (samples on the falling clock edge)
   logic [7:0]  rx_byte[$];
   bit          rx_shape[$];
   int          rx_gap[$];
   logic [31:0] rx_addr[$];
   int          rx_stab[$];
   logic        rx_sel[$];

   logic [FB-1:0] samp;
   int            hi_run;
   int            stab;
   logic [31:0]   prev_addr;
   bit            aborted;
   bit            shape;
   logic [7:0]    dbyte;
   logic [31:0]   f_addr;
   int            f_stab;
   int            f_gap;
   logic          f_sel;

   task automatic upd_stab();
      if (mem_address === prev_addr) stab++;
      else stab = 0;
      prev_addr = mem_address;
   endtask

   initial begin
      hi_run    = 1000;
      stab      = 0;
      prev_addr = '0;
      forever begin
         @(negedge clk);
         upd_stab();
         if (!rst_n || tx !== 1'b0) begin
            hi_run++;
            continue;
         end
         f_addr  = mem_address;
         f_stab  = stab;
         f_gap   = hi_run;
         f_sel   = mem_sel;
         samp    = '0;
         aborted = 0;
         for (int j = 1; j < FB; j++) begin
            @(negedge clk);
            upd_stab();
            if (!rst_n) begin
               aborted = 1;
               break;
            end
            samp[j] = tx;
         end
         if (aborted) begin
            hi_run = 1000;
            continue;
         end
         shape = 1;
         for (int c = 0; c < 10; c++)
            for (int s = 1; s < CPB; s++)
               if (samp[c*CPB+s] !== samp[c*CPB]) shape = 0;
         if (samp[0] !== 1'b0 || samp[9*CPB] !== 1'b1) shape = 0;
         for (int b = 0; b < 8; b++) dbyte[b] = samp[(b+1)*CPB + CPB/2];
         rx_byte.push_back(dbyte);
         rx_shape.push_back(shape);
         rx_gap.push_back(f_gap);
         rx_addr.push_back(f_addr);
         rx_stab.push_back(f_stab);
         rx_sel.push_back(f_sel);
         hi_run = 0;
      end
   end

   task automatic clear_rx();
      rx_byte.delete();
      rx_shape.delete();
      rx_gap.delete();
      rx_addr.delete();
      rx_stab.delete();
      rx_sel.delete();
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // One full dump; optionally a second start lands in the middle of frame 2.
   task automatic run_dump(input string tag, input logic [7:0] m, input logic [23:0] up,
                           input bit extra);
      int  cyc;
      int  extra_at;
      int  exp_n;
      bit  got_done;
      logic [7:0]  eb;
      logic [31:0] ea;
      mask  = m;
      upper = up;
      exp_n = N;
`ifdef DUMP_CHECKSUM_EN
      exp_n = N + 1;
`endif
      repeat (4) @(negedge clk);
      clear_rx();
      pulse_start();
      cyc      = 0;
      got_done = 0;
      extra_at = $urandom_range(85, 55);
      while (!got_done && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         start = extra && (cyc == extra_at);
         if (done === 1'b1) got_done = 1;
      end
      start = 1'b0;
      check_val({tag, "_done_seen"}, 32'(got_done), 32'd1);
      check_val({tag, "_memsel_in_done"}, 32'(mem_sel), 32'd0);
      @(negedge clk);
      check_val({tag, "_busy_after_done"}, 32'(busy), 32'd0);
      check_val({tag, "_done_one_cycle"}, 32'(done), 32'd0);
      repeat (30) @(negedge clk);
      check_val({tag, "_frame_count"}, 32'(rx_byte.size()), 32'(exp_n));
      for (int i = 0; i < rx_byte.size() && i < exp_n; i++) begin
         eb = (i < N) ? pix(i) : csum();
         ea = (i < N) ? BASE + i : BASE + N - 1;
         check_val($sformatf("%s_byte%0d", tag, i), 32'(rx_byte[i]), 32'(eb));
         check_val($sformatf("%s_shape%0d", tag, i), 32'(rx_shape[i]), 32'd1);
         check_val($sformatf("%s_addr%0d", tag, i), rx_addr[i], ea);
         check_val($sformatf("%s_sel%0d", tag, i), 32'(rx_sel[i]), 32'd1);
         check_val($sformatf("%s_addr_stable%0d", tag, i),
                   32'(rx_stab[i] >= int'(LAT)), 32'd1);
         if (i > 0)
            check_val($sformatf("%s_gap%0d", tag, i),
                      32'(rx_gap[i] >= int'(LAT + 2)), 32'd1);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      mask  = 8'h00;
      upper = 24'hA5A500;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (50) @(negedge clk);
      check_val("idle_tx", 32'(tx), 32'd1);
      check_val("idle_busy", 32'(busy), 32'd0);
      check_val("idle_mem_sel", 32'(mem_sel), 32'd0);
      check_val("idle_done", 32'(done), 32'd0);
      check_val("idle_mem_address", mem_address, BASE);

      // Plain pattern with a stray start during frame 2, then inverted pattern.
      run_dump("plain", 8'h00, 24'hA5A500, 1'b1);
      run_dump("inv", 8'hFF, 24'($urandom), 1'b0);

      // Reset in the middle of frame 3.
      mask = 8'h00;
      pulse_start();
      repeat ($urandom_range(125, 105)) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("rst_tx", 32'(tx), 32'd1);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_mem_sel", 32'(mem_sel), 32'd0);
      check_val("rst_mem_address", mem_address, BASE);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      run_dump("restart", 8'h00, 24'hA5A500, 1'b0);

      for (int r = 0; r < 3; r++)
         run_dump($sformatf("rand%0d", r), 8'($urandom), 24'($urandom), 1'($urandom));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
